// File: rtl/inv_mixcolumns_pipe.sv
// inv_mixcolumns_pipe: two-stage AES InvMixColumns with valid/ready flow control.
// Stage 1 pre-conditions each column so that stage 2 can reuse the forward
// MixColumns matrix. The result is InvMixColumns(a).
// Optional feature macro: INV_MIXCOL_LAST_ROUND_EN adds a last_round input.
// When last_round is set, the state passes through unchanged with the same
// latency and handshake. This serves the decrypt round that has no InvMixColumns.
module inv_mixcolumns_pipe (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] a,
`ifdef INV_MIXCOL_LAST_ROUND_EN
  input  logic         last_round,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] b
);

  // GF(2^8) multiply by x, reduction polynomial 0x11B
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column pre-conditioning: {x0^u, x1^v, x2^u, x3^v}, where u = 4*(x0^x2) and v = 4*(x1^x3)
  function automatic logic [31:0] precond_col(input logic [31:0] c);
    logic [7:0] u;
    logic [7:0] v;
    u = xt(xt(c[7:0] ^ c[23:16]));
    v = xt(xt(c[15:8] ^ c[31:24]));
    return {c[31:24] ^ v, c[23:16] ^ u, c[15:8] ^ v, c[7:0] ^ u};
  endfunction

  // Forward MixColumns on one column, circulant {02,03,01,01}
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    x0 = c[7:0];
    x1 = c[15:8];
    x2 = c[23:16];
    x3 = c[31:24];
    return {xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3),
            x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3,
            x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3,
            xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3};
  endfunction

  logic         s1_valid_r;
  logic         s2_valid_r;
  logic [127:0] s1_data_r;
  logic [127:0] b_r;
  logic [127:0] precond_s;
  logic [127:0] mix_s;
  logic         adv1_s;
  logic         adv2_s;
  logic         in_fire_s;
`ifdef INV_MIXCOL_LAST_ROUND_EN
  logic         s1_last_r;
`endif

  // A stage advances when it is empty or when its successor advances; there is no skid buffer
  always_comb begin
    adv2_s    = !s2_valid_r || out_ready;
    adv1_s    = !s1_valid_r || adv2_s;
    in_fire_s = in_valid && adv1_s;
  end

  assign in_ready  = adv1_s;
  assign out_valid = s2_valid_r;
  assign b         = b_r;

  // Per-column datapath for both stages
  always_comb begin
    precond_s = 128'h0;
    mix_s     = 128'h0;
    for (int c = 0; c < 4; c++) begin
      precond_s[32*c +: 32] = precond_col(a[32*c +: 32]);
      mix_s[32*c +: 32]     = mix_col(s1_data_r[32*c +: 32]);
    end
  end

  // Stage 1: capture the pre-conditioned state on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 128'h0;
`ifdef INV_MIXCOL_LAST_ROUND_EN
      s1_last_r  <= 1'b0;
`endif
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
`ifdef INV_MIXCOL_LAST_ROUND_EN
      s1_last_r  <= in_fire_s && last_round;
      if (in_fire_s) begin
        s1_data_r <= last_round ? a : precond_s;
      end
`else
      if (in_fire_s) begin
        s1_data_r <= precond_s;
      end
`endif
    end
  end

  // Stage 2: apply MixColumns; b keeps the last result while no new state arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      b_r        <= 128'h0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
`ifdef INV_MIXCOL_LAST_ROUND_EN
        b_r <= s1_last_r ? s1_data_r : mix_s;
`else
        b_r <= mix_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_pipe.sv
// Directed testbench for inv_mixcolumns_pipe. It covers reset, the FIPS-197
// vector, the identity and zero states, a back-to-back round trip through a
// forward MixColumns model, backpressure, mid-operation reset and, when
// INV_MIXCOL_LAST_ROUND_EN is defined, the last-round bypass.
module tb_inv_mixcolumns_pipe;

  localparam logic [127:0] FIPS_A   = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
  localparam logic [127:0] FIPS_B   = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
  localparam logic [127:0] IDENT_A  = 128'h01010101_01010101_01010101_01010101;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] b;
`ifdef INV_MIXCOL_LAST_ROUND_EN
  logic         last_round;
`endif

  int checks;
  int errors;

  inv_mixcolumns_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
`ifdef INV_MIXCOL_LAST_ROUND_EN
    .last_round(last_round),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply, poly 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = xx[7] ? ({xx[6:0], 1'b0} ^ 8'h1b) : {xx[6:0], 1'b0};
    end
    return p;
  endfunction

  // Reference forward MixColumns on a whole state
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   col [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) col[k] = s[8*(k+4*c) +: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], col[k]);
        r[8*(row+4*c) +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 128'h0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      a = {$urandom, $urandom, $urandom, $urandom};
      step;
      checks++;
      if (out_valid !== 1'b0 || b !== 128'h0) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b b=%h, expected 0 and 0", out_valid, b);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || b !== 128'h0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b b=%h, expected 1 0 0", in_ready, out_valid, b);
    end
    step;
  endtask

  task automatic test_fips;
    out_ready = 1'b1; in_valid = 1'b1; a = FIPS_A;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_in_ready: got %b expected 1", in_ready);
    end
    step;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_lat1: out_valid=%b expected 0", out_valid);
    end
    step;
    checks++;
    if (out_valid !== 1'b1 || b !== FIPS_B) begin
      errors++;
      $display("FAIL fips_result: out_valid=%b b=%h expected 1 %h", out_valid, b, FIPS_B);
    end
    step;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_drain: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_identity_zero;
    logic [127:0] vin [2];
    vin[0] = IDENT_A;
    vin[1] = 128'h0;
    out_ready = 1'b1;
    // Start from a nonzero b so that the zero result is an actual load
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = vin[i];
      step;
      in_valid = 1'b0; a = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
      step;
      checks++;
      if (out_valid !== 1'b1 || b !== vin[i]) begin
        errors++;
        $display("FAIL ident_zero_%0d: out_valid=%b b=%h expected 1 %h", i, out_valid, b, vin[i]);
      end
      step;
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vec [16];
    int sent, got, cyc;
    logic in_fire, out_fire;
    for (int i = 0; i < 16; i++) vec[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; sent = 0; got = 0; cyc = 0;
    while (got < 16 && cyc < 60) begin
      if (sent < 16) begin
        in_valid = 1'b1; a = vec[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", cyc, in_ready);
        end
      end
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        checks++;
        if (got >= 16) begin
          errors++;
          $display("FAIL b2b_extra: unexpected output %h", b);
        end else if (fwd_mix(b) !== vec[got]) begin
          errors++;
          $display("FAIL b2b_roundtrip_%0d: mix(b)=%h expected %h", got, fwd_mix(b), vec[got]);
        end
        got++;
      end
      in_fire = in_valid && in_ready;
      step;
      if (in_fire) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16 || sent != 16) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d got=%0d expected 16 16", sent, got);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] vec [3];
    logic [127:0] hold;
    int sent, got, cyc;
    logic in_fire, out_fire;
    vec[0] = FIPS_A;
    vec[1] = {$urandom, $urandom, $urandom, $urandom};
    vec[2] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0; sent = 0; got = 0; hold = 128'h0;
    for (int k = 0; k < 7; k++) begin
      if (sent < 3) begin
        in_valid = 1'b1; a = vec[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k >= 2) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || b !== hold) begin
          errors++;
          $display("FAIL bp_stall_%0d: in_ready=%b out_valid=%b b=%h expected 0 1 %h", k, in_ready, out_valid, b, hold);
        end
      end
      in_fire = in_valid && in_ready;
      step;
      if (in_fire) sent++;
      if (k == 1) hold = FIPS_B;
    end
    checks++;
    if (sent != 2) begin
      errors++;
      $display("FAIL bp_accepted: sent=%0d expected 2", sent);
    end
    out_ready = 1'b1; cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (sent < 3) begin
        in_valid = 1'b1; a = vec[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        checks++;
        if (fwd_mix(b) !== vec[got]) begin
          errors++;
          $display("FAIL bp_order_%0d: mix(b)=%h expected %h", got, fwd_mix(b), vec[got]);
        end
        got++;
      end
      in_fire = in_valid && in_ready;
      step;
      if (in_fire) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_dup: extra out_valid=%b expected 0", out_valid);
      end
      step;
    end
    checks++;
    if (got != 3 || sent != 3) begin
      errors++;
      $display("FAIL bp_count: sent=%0d got=%0d expected 3 3", sent, got);
    end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; a = FIPS_A;
    step;
    a = IDENT_A;
    step;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre: out_valid=%b expected 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || b !== 128'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mrst_async: out_valid=%b b=%h in_ready=%b expected 0 0 1", out_valid, b, in_ready);
    end
    step;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mrst_stale: cycle %0d out_valid=%b expected 0", k, out_valid);
      end
    end
  endtask

`ifdef INV_MIXCOL_LAST_ROUND_EN
  task automatic test_last_round;
    out_ready = 1'b1;
    in_valid = 1'b1; a = FIPS_A; last_round = 1'b1;
    step;
    in_valid = 1'b0; last_round = 1'b0; a = 128'h0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lr_lat1: out_valid=%b expected 0", out_valid);
    end
    step;
    checks++;
    if (out_valid !== 1'b1 || b !== FIPS_A) begin
      errors++;
      $display("FAIL lr_bypass: out_valid=%b b=%h expected 1 %h", out_valid, b, FIPS_A);
    end
    in_valid = 1'b1; a = FIPS_A; last_round = 1'b0;
    step;
    in_valid = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b1 || b !== FIPS_B) begin
      errors++;
      $display("FAIL lr_normal: out_valid=%b b=%h expected 1 %h", out_valid, b, FIPS_B);
    end
    step;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
`ifdef INV_MIXCOL_LAST_ROUND_EN
    last_round = 1'b0;
`endif
    test_reset;
    test_fips;
    test_identity_zero;
    test_back_to_back;
    test_backpressure;
    test_mid_reset;
`ifdef INV_MIXCOL_LAST_ROUND_EN
    test_last_round;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
